// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and
// default timing constants.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W      = 20;
  localparam int unsigned DEF_ON_CYCLES  = 20'hFFFFF;
  localparam int unsigned DEF_OFF_CYCLES = 20'hFFFFF;
  localparam int unsigned DEF_PEND_W     = 4;

  // True when a cycle count fits the legal range 1..2**width-1.
  function automatic bit cycles_legal(input longint unsigned cycles,
                                      input int unsigned     width);
    return (cycles != 0) && ((cycles >> width) == 0);
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches single-cycle trigger events into fixed-length visible pulses
// separated by a mandatory low gap, queueing events that arrive while busy.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  if (!cycles_legal(longint'(ON_CYCLES), CNT_W)) begin : g_bad_on
    $error("pulse_stretch: ON_CYCLES must be in 1..2**CNT_W-1");
  end
  if (!cycles_legal(longint'(OFF_CYCLES), CNT_W)) begin : g_bad_off
    $error("pulse_stretch: OFF_CYCLES must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              enqueue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      level_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    enqueue = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ON;
          cnt_d   = ON_LOAD;
        end
      end

      ON: begin
        enqueue = trigger;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          // Oldest queued event starts first; a same-cycle trigger takes its
          // place in the queue (net zero) or is consumed directly if empty.
          if (pend_q != '0) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
            if (!trigger) begin
              pend_d = pend_q - 1'b1;
            end
          end else if (trigger) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q - 1'b1;
          enqueue = trigger;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enqueue) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end

    level_d = (state_d == ON);
  end

  assign level    = level_q;
  assign busy     = (state_q != IDLE);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: one DUT with ON=4/OFF=2/PEND_W=2 and one
// with ON=1/OFF=1, driven on a shared clock and reset.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trig_a = 1'b0;
  logic       trig_b = 1'b0;
  logic       lvl_a, busy_a, ovf_a;
  logic       lvl_b, busy_b, ovf_b;
  logic [1:0] pend_a, pend_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_stretch #(.CNT_W(8), .ON_CYCLES(4), .OFF_CYCLES(2), .PEND_W(2)) dut_a (
    .clk(clk), .reset(reset), .trigger(trig_a),
    .level(lvl_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  pulse_stretch #(.CNT_W(8), .ON_CYCLES(1), .OFF_CYCLES(1), .PEND_W(2)) dut_b (
    .clk(clk), .reset(reset), .trigger(trig_b),
    .level(lvl_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset still visible, released at the next edge.
  task automatic start();
    reset = 1'b1; trig_a = 1'b0; trig_b = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; trig_a = 1'b1; trig_b = 1'b1;
    tick(); tick();
    n_checks++;
    if ({lvl_a, busy_a, pend_a, ovf_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a got lvl=%b busy=%b pend=%0d ovf=%b exp all 0", lvl_a, busy_a, pend_a, ovf_a);
    end
    n_checks++;
    if ({lvl_b, busy_b, pend_b, ovf_b} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_b got lvl=%b busy=%b pend=%0d ovf=%b exp all 0", lvl_b, busy_b, pend_b, ovf_b);
    end
    // First trigger right after reset release: level rises one cycle later.
    reset = 1'b0; trig_a = 1'b1; trig_b = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      trig_a = 1'b0;
      n_checks++;
      if (lvl_a !== (t >= 1 && t <= 4)) begin
        n_fail++;
        $display("FAIL post_reset_level t=%0d got %b exp %b", t, lvl_a, (t >= 1 && t <= 4));
      end
    end
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_single();
    logic el, eb;
    start();
    for (int t = 0; t <= 20; t++) begin
      trig_a = (t == 10);
      el = (t >= 11 && t <= 14);
      eb = (t >= 11 && t <= 16);
      n_checks++;
      if (lvl_a !== el) begin
        n_fail++;
        $display("FAIL single_level t=%0d got %b exp %b", t, lvl_a, el);
      end
      n_checks++;
      if (busy_a !== eb) begin
        n_fail++;
        $display("FAIL single_busy t=%0d got %b exp %b", t, busy_a, eb);
      end
      n_checks++;
      if (pend_a !== 2'd0 || ovf_a !== 1'b0) begin
        n_fail++;
        $display("FAIL single_pend t=%0d got pend=%0d ovf=%b exp 0 0", t, pend_a, ovf_a);
      end
      tick();
    end
    $display("test_single done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_three_triggers();
    logic el;
    logic [1:0] ep;
    start();
    for (int t = 0; t <= 30; t++) begin
      trig_a = (t == 10 || t == 12 || t == 13);
      el = (t >= 11 && t <= 14) || (t >= 17 && t <= 20) || (t >= 23 && t <= 26);
      if (t == 13)                ep = 2'd1;
      else if (t >= 14 && t <= 16) ep = 2'd2;
      else if (t >= 17 && t <= 22) ep = 2'd1;
      else                         ep = 2'd0;
      n_checks++;
      if (lvl_a !== el) begin
        n_fail++;
        $display("FAIL three_level t=%0d got %b exp %b", t, lvl_a, el);
      end
      n_checks++;
      if (pend_a !== ep) begin
        n_fail++;
        $display("FAIL three_pend t=%0d got %0d exp %0d", t, pend_a, ep);
      end
      tick();
    end
    $display("test_three_triggers done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_saturate();
    logic [1:0] ep;
    logic       prev;
    int         pulses, ovfs;
    start();
    prev = 1'b0; pulses = 0; ovfs = 0;
    for (int t = 0; t <= 45; t++) begin
      trig_a = (t >= 10 && t <= 17);
      if (t < 12)       ep = 2'd0;
      else if (t == 12) ep = 2'd1;
      else if (t == 13) ep = 2'd2;
      else if (t <= 22) ep = 2'd3;
      else if (t <= 28) ep = 2'd2;
      else if (t <= 34) ep = 2'd1;
      else              ep = 2'd0;
      n_checks++;
      if (pend_a !== ep) begin
        n_fail++;
        $display("FAIL sat_pend t=%0d got %0d exp %0d", t, pend_a, ep);
      end
      if (t == 15) begin
        n_checks++;
        if (ovf_a !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_ovf_first t=15 got %b exp 1", ovf_a);
        end
      end
      if (t == 17) begin
        n_checks++;
        if (ovf_a !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_ovf_gap_end t=17 got %b exp 0", ovf_a);
        end
      end
      if (lvl_a === 1'b1 && prev === 1'b0) pulses++;
      if (ovf_a === 1'b1) ovfs++;
      prev = lvl_a;
      tick();
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL sat_pulses got %0d exp 5", pulses);
    end
    n_checks++;
    if (ovfs != 3) begin
      n_fail++;
      $display("FAIL sat_ovf_count got %0d exp 3", ovfs);
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_idle_busy got %b exp 0", busy_a);
    end
    $display("test_saturate done: pulses=%0d ovfs=%0d checks=%0d failures=%0d", pulses, ovfs, n_checks, n_fail);
  endtask

  task automatic test_gap_end_trigger();
    logic prev;
    int   pulses;
    start();
    prev = 1'b0; pulses = 0;
    for (int t = 0; t <= 35; t++) begin
      trig_a = (t == 10 || t == 12 || t == 16);
      n_checks++;
      if (ovf_a !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_ovf t=%0d got %b exp 0", t, ovf_a);
      end
      if (t == 17 || t == 23) begin
        n_checks++;
        if (lvl_a !== 1'b1 || pend_a !== ((t == 17) ? 2'd1 : 2'd0)) begin
          n_fail++;
          $display("FAIL gap_restart t=%0d got lvl=%b pend=%0d exp lvl=1 pend=%0d", t, lvl_a, pend_a, (t == 17) ? 1 : 0);
        end
      end
      if (lvl_a === 1'b1 && prev === 1'b0) pulses++;
      prev = lvl_a;
      tick();
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL gap_pulses got %0d exp 3", pulses);
    end
    $display("test_gap_end_trigger done: pulses=%0d checks=%0d failures=%0d", pulses, n_checks, n_fail);
  endtask

  task automatic test_reset_mid_pulse();
    logic el;
    start();
    for (int t = 0; t <= 30; t++) begin
      trig_a = (t == 10 || t == 11 || t == 12 || t == 13 || t == 20);
      reset  = (t == 13);
      if (t == 13) begin
        n_checks++;
        if (lvl_a !== 1'b1 || pend_a !== 2'd2) begin
          n_fail++;
          $display("FAIL mid_pre t=13 got lvl=%b pend=%0d exp lvl=1 pend=2", lvl_a, pend_a);
        end
      end
      if (t == 14) begin
        n_checks++;
        if ({lvl_a, busy_a, pend_a, ovf_a} !== 5'b0) begin
          n_fail++;
          $display("FAIL mid_reset t=14 got lvl=%b busy=%b pend=%0d ovf=%b exp all 0", lvl_a, busy_a, pend_a, ovf_a);
        end
      end
      if (t >= 15) begin
        el = (t >= 21 && t <= 24);
        n_checks++;
        if (lvl_a !== el || pend_a !== 2'd0) begin
          n_fail++;
          $display("FAIL mid_after t=%0d got lvl=%b pend=%0d exp lvl=%b pend=0", t, lvl_a, pend_a, el);
        end
      end
      tick();
    end
    reset = 1'b0;
    $display("test_reset_mid_pulse done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_min_timing();
    logic el, prev;
    int   pulses;
    start();
    prev = 1'b0; pulses = 0;
    for (int t = 0; t <= 22; t++) begin
      trig_b = (t >= 10 && t <= 13);
      el = (t == 11 || t == 13 || t == 15 || t == 17);
      n_checks++;
      if (lvl_b !== el) begin
        n_fail++;
        $display("FAIL min_level t=%0d got %b exp %b", t, lvl_b, el);
      end
      n_checks++;
      if (ovf_b !== 1'b0) begin
        n_fail++;
        $display("FAIL min_ovf t=%0d got %b exp 0", t, ovf_b);
      end
      if (t == 14) begin
        n_checks++;
        if (pend_b !== 2'd2) begin
          n_fail++;
          $display("FAIL min_pend t=14 got %0d exp 2", pend_b);
        end
      end
      if (lvl_b === 1'b1 && prev === 1'b0) pulses++;
      prev = lvl_b;
      tick();
    end
    n_checks++;
    if (pulses != 4 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL min_pulses got pulses=%0d busy=%b exp 4 0", pulses, busy_b);
    end
    $display("test_min_timing done: pulses=%0d checks=%0d failures=%0d", pulses, n_checks, n_fail);
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_triggers();
    test_saturate();
    test_gap_end_trigger();
    test_reset_mid_pulse();
    test_min_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
